// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM-subset control path: opcode classes, DP commands,
// ALU operations, condition codes, extend/register-select modes and stage bundles.
package arm_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
        COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf
    } cond_e;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REGSRC_DP  = 2'b00;
    localparam logic [1:0] REGSRC_BR  = 2'b01;
    localparam logic [1:0] REGSRC_STR = 2'b10;

    typedef struct packed {
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       branch;
        logic       pcs;
        logic       alu_src;
        logic [2:0] alu_ctl;
        logic [1:0] flag_w;
        logic [3:0] cond;
    } de_ctrl_t;

    typedef struct packed {
        logic reg_w;
        logic mem_w;
        logic pc_src;
        logic mem_to_reg;
    } em_ctrl_t;

    typedef struct packed {
        logic reg_w;
        logic pc_src;
        logic mem_to_reg;
    } mw_ctrl_t;

endpackage

// File: rtl/cond_unit.sv
// Execute-stage condition check against the NZCV flags register, plus the
// per-half write enables that let a passing flag-setting instruction update it.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] flag_w,
    input  logic [3:0] alu_flags,
    output logic       cond_ex
);

    logic [3:0] flags;
    logic       n, z, c, v;
    logic [1:0] flag_we;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
        endcase
    end

    // A failed condition must not leak flag updates from the squashed instruction.
    assign flag_we = flag_w & {2{cond_ex}};

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'h0;
        end else begin
            if (flag_we[1]) flags[3:2] <= alu_flags[3:2];
            if (flag_we[0]) flags[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// Control unit for the 5-stage ARM-subset pipeline: Decode-stage decoder and the
// D/E, E/M, M/W control registers, with condition gating applied in Execute.
module pipe_controller
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] InstrD,
    input  logic [3:0]  ALUFlags,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic        MemWriteM,
    output logic        MemtoRegW,
    output logic        RegWriteW,
    output logic        PCSrcW,
    output logic        PCWrPendingF
);

    logic [3:0] cond_d;
    logic [1:0] op_d;
    logic [5:0] funct_d;
    logic [3:0] rd_d;
    logic       unused_rn;
    logic       dp_ok;
    logic       cond_ex;

    de_ctrl_t de_next, de_q;
    em_ctrl_t em_next, em_q;
    mw_ctrl_t mw_q;

    assign cond_d    = InstrD[19:16];
    assign op_d      = InstrD[15:14];
    assign funct_d   = InstrD[13:8];
    assign rd_d      = InstrD[3:0];
    assign unused_rn = ^InstrD[7:4];

    always_comb begin
        de_next      = '0;
        dp_ok        = 1'b0;
        RegSrcD      = REGSRC_DP;
        ImmSrcD      = IMM_DP;
        de_next.cond = cond_d;
        case (op_e'(op_d))
            OP_DP: begin
                dp_ok = 1'b1;
                case (funct_d[4:1])
                    CMD_ADD: begin
                        de_next.reg_w   = 1'b1;
                        de_next.alu_ctl = ALU_ADD;
                        de_next.flag_w  = {2{funct_d[0]}};
                    end
                    CMD_SUB: begin
                        de_next.reg_w   = 1'b1;
                        de_next.alu_ctl = ALU_SUB;
                        de_next.flag_w  = {2{funct_d[0]}};
                    end
                    CMD_AND: begin
                        de_next.reg_w   = 1'b1;
                        de_next.alu_ctl = ALU_AND;
                        de_next.flag_w  = {funct_d[0], 1'b0};
                    end
                    CMD_ORR: begin
                        de_next.reg_w   = 1'b1;
                        de_next.alu_ctl = ALU_ORR;
                        de_next.flag_w  = {funct_d[0], 1'b0};
                    end
                    // CMP is a SUB whose only effect is the flags, whatever S says.
                    CMD_CMP: begin
                        de_next.alu_ctl = ALU_SUB;
                        de_next.flag_w  = 2'b11;
                    end
                    default: dp_ok = 1'b0;
                endcase
                de_next.alu_src = funct_d[5] & dp_ok;
            end
            OP_MEM: begin
                ImmSrcD         = IMM_MEM;
                de_next.alu_src = 1'b1;
                de_next.alu_ctl = ALU_ADD;
                if (funct_d[0]) begin
                    de_next.reg_w      = 1'b1;
                    de_next.mem_to_reg = 1'b1;
                end else begin
                    RegSrcD       = REGSRC_STR;
                    de_next.mem_w = 1'b1;
                end
            end
            OP_BR: begin
                ImmSrcD         = IMM_BR;
                RegSrcD         = REGSRC_BR;
                de_next.alu_src = 1'b1;
                de_next.alu_ctl = ALU_ADD;
                de_next.branch  = 1'b1;
            end
            default: ;
        endcase
        de_next.pcs = ((rd_d == 4'hF) & de_next.reg_w) | de_next.branch;
    end

    cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (de_q.cond),
        .flag_w    (de_q.flag_w),
        .alu_flags (ALUFlags),
        .cond_ex   (cond_ex)
    );

    always_comb begin
        em_next            = '0;
        em_next.reg_w      = de_q.reg_w & cond_ex;
        em_next.mem_w      = de_q.mem_w & cond_ex;
        em_next.pc_src     = (de_q.pcs | de_q.branch) & cond_ex;
        em_next.mem_to_reg = de_q.mem_to_reg;
    end

    // FlushE only bubbles D/E; later stages keep draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            de_q <= '0;
            em_q <= '0;
            mw_q <= '0;
        end else begin
            de_q            <= FlushE ? '0 : de_next;
            em_q            <= em_next;
            mw_q.reg_w      <= em_q.reg_w;
            mw_q.pc_src     <= em_q.pc_src;
            mw_q.mem_to_reg <= em_q.mem_to_reg;
        end
    end

    assign ALUSrcE      = de_q.alu_src;
    assign ALUControlE  = de_q.alu_ctl;
    assign MemWriteM    = em_q.mem_w;
    assign MemtoRegW    = mw_q.mem_to_reg;
    assign RegWriteW    = mw_q.reg_w;
    assign PCSrcW       = mw_q.pc_src;
    assign PCWrPendingF = de_next.pcs | em_next.pc_src | em_q.pc_src;

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: directed scenarios plus a randomized run,
// all compared against an instruction-level reference model of the pipeline.
module tb_pipe_controller;

    localparam int W = 17;
    localparam logic [19:0] NOP = {4'he, 2'b11, 14'h0};

    logic        clk;
    logic        reset;
    logic [19:0] InstrD;
    logic [3:0]  ALUFlags;
    logic        FlushE;
    logic [1:0]  RegSrcD;
    logic [1:0]  ImmSrcD;
    logic        ALUSrcE;
    logic [2:0]  ALUControlE;
    logic        MemWriteM;
    logic        MemtoRegW;
    logic        RegWriteW;
    logic        PCSrcW;
    logic        PCWrPendingF;

    int n_vec = 0;
    int n_err = 0;

    // obs/exp layout: {RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM,
    //                  MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF, Flags}
    logic [W-1:0] obs;
    logic [W-1:0] exp_q[$];

    pipe_controller dut (
        .clk          (clk),
        .reset        (reset),
        .InstrD       (InstrD),
        .ALUFlags     (ALUFlags),
        .FlushE       (FlushE),
        .RegSrcD      (RegSrcD),
        .ImmSrcD      (ImmSrcD),
        .ALUSrcE      (ALUSrcE),
        .ALUControlE  (ALUControlE),
        .MemWriteM    (MemWriteM),
        .MemtoRegW    (MemtoRegW),
        .RegWriteW    (RegWriteW),
        .PCSrcW       (PCSrcW),
        .PCWrPendingF (PCWrPendingF)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum logic [3:0] {K_ADD, K_SUB, K_AND, K_ORR, K_CMP, K_LDR, K_STR, K_B, K_NOP} kind_e;

    typedef struct packed {
        logic [1:0] reg_src;
        logic [1:0] imm_src;
        logic       alu_src;
        logic [2:0] alu_ctl;
        logic       reg_w;
        logic       mem_w;
        logic       m2r;
        logic       branch;
        logic       pcs;
        logic [1:0] flag_w;
        logic [3:0] cond;
    } mctl_t;

    typedef struct packed {
        logic reg_w;
        logic mem_w;
        logic pc_src;
        logic m2r;
    } eff_t;

    mctl_t      m_e = '0;
    eff_t       m_m = '0;
    eff_t       m_w = '0;
    logic [3:0] m_flags = 4'h0;

    function automatic kind_e classify(input logic [19:0] i);
        logic [1:0] op;
        op = i[15:14];
        if (op == 2'd1) return i[8] ? K_LDR : K_STR;
        if (op == 2'd2) return K_B;
        if (op == 2'd0) begin
            case (i[12:9])
                4'd4:  return K_ADD;
                4'd2:  return K_SUB;
                4'd0:  return K_AND;
                4'd12: return K_ORR;
                4'd10: return K_CMP;
                default: return K_NOP;
            endcase
        end
        return K_NOP;
    endfunction

    function automatic mctl_t model_decode(input logic [19:0] i);
        mctl_t c;
        kind_e k;
        logic  s;
        c = '0;
        k = classify(i);
        s = i[8];
        c.cond = i[19:16];
        case (k)
            K_ADD, K_SUB, K_AND, K_ORR: begin
                c.reg_w   = 1'b1;
                c.alu_src = i[13];
                c.alu_ctl = (k == K_ADD) ? 3'd0 : (k == K_SUB) ? 3'd1 : (k == K_AND) ? 3'd2 : 3'd3;
                c.flag_w  = {s, s & ((k == K_ADD) || (k == K_SUB))};
            end
            K_CMP: begin
                c.alu_src = i[13];
                c.alu_ctl = 3'd1;
                c.flag_w  = 2'b11;
            end
            K_LDR: begin
                c.imm_src = 2'd1; c.alu_src = 1'b1; c.reg_w = 1'b1; c.m2r = 1'b1;
            end
            K_STR: begin
                c.imm_src = 2'd1; c.reg_src = 2'd2; c.alu_src = 1'b1; c.mem_w = 1'b1;
            end
            K_B: begin
                c.imm_src = 2'd2; c.reg_src = 2'd1; c.alu_src = 1'b1; c.branch = 1'b1;
            end
            default: ;
        endcase
        c.pcs = c.branch | (c.reg_w & (i[3:0] == 4'hf));
        return c;
    endfunction

    // Codes 0..13 pair up: odd code is the negation of the even one below it.
    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        if (cond == 4'he) return 1'b1;
        if (cond == 4'hf) return 1'b0;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b0;
        endcase
        return base ^ cond[0];
    endfunction

    function automatic logic [W-1:0] model_expect(input logic [19:0] ins);
        mctl_t d;
        logic  pc_e;
        d    = model_decode(ins);
        pc_e = m_e.pcs & cond_ok(m_e.cond, m_flags);
        return {d.reg_src, d.imm_src, m_e.alu_src, m_e.alu_ctl, m_m.mem_w,
                m_w.m2r, m_w.reg_w, m_w.pc_src, d.pcs | pc_e | m_m.pc_src, m_flags};
    endfunction

    task automatic model_advance(input logic [19:0] ins, input logic [3:0] af,
                                 input logic fl, input logic rs);
        logic ok;
        eff_t e;
        if (rs) begin
            m_e = '0; m_m = '0; m_w = '0; m_flags = 4'h0;
        end else begin
            ok       = cond_ok(m_e.cond, m_flags);
            e.reg_w  = m_e.reg_w & ok;
            e.mem_w  = m_e.mem_w & ok;
            e.pc_src = m_e.pcs & ok;
            e.m2r    = m_e.m2r;
            if (m_e.flag_w[1] && ok) m_flags[3:2] = af[3:2];
            if (m_e.flag_w[0] && ok) m_flags[1:0] = af[1:0];
            m_w = m_m;
            m_m = e;
            m_e = fl ? '0 : model_decode(ins);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic [19:0] ins, input logic [3:0] af,
                         input logic fl, input logic rs);
        InstrD   = ins;
        ALUFlags = af;
        FlushE   = fl;
        reset    = rs;
        exp_q.push_back(model_expect(ins));
        @(negedge clk);
        obs = {RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, MemtoRegW,
               RegWriteW, PCSrcW, PCWrPendingF, dut.u_cond.flags};
        @(posedge clk);
        model_advance(ins, af, fl, rs);
        #1;
    endtask

    task automatic apply_reset();
        cycle(NOP, 4'h0, 1'b0, 1'b1);
        void'(exp_q.pop_front());
    endtask

    function automatic logic [19:0] rand_instr();
        logic [19:0] r;
        logic [3:0]  cmds [5];
        cmds = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd10};
        r = 20'($urandom);
        case ($urandom_range(0, 5))
            0, 1: begin
                r[15:14] = 2'b00;
                r[12:9]  = cmds[$urandom_range(0, 4)];
            end
            2: r[15:14] = 2'b01;
            3: r[15:14] = 2'b10;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) r[3:0] = 4'hf;
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] e;
        apply_reset();
        cycle({4'he, 2'b01, 6'b011000, 4'h0, 4'h2}, 4'hf, 1'b0, 1'b1);
        e = exp_q.pop_front(); n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL reset_hold: got %h expected %h", obs, e); end
        n_vec++;
        if (obs[16:13] !== 4'b1001) begin
            n_err++; $display("FAIL reset_dsel: got %b expected 1001", obs[16:13]);
        end
        cycle(NOP, 4'hf, 1'b0, 1'b0);
        e = exp_q.pop_front(); n_vec++;
        if (obs !== e) begin n_err++; $display("FAIL reset_release: got %h expected %h", obs, e); end
        n_vec++;
        if (obs[12:0] !== 13'h0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0000", obs[12:0]);
        end
    endtask

    task automatic test_add_imm();
        logic [W-1:0] e;
        logic [19:0]  add_i;
        add_i = {4'he, 2'b00, 6'b101000, 4'h2, 4'h1};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            cycle((k == 0) ? add_i : NOP, 4'hf, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL add_imm c%0d: got %h expected %h", k, obs, e); end
            if (k == 1) begin
                n_vec++;
                if (obs[12:9] !== 4'b1000) begin
                    n_err++; $display("FAIL add_imm_e: got %b expected 1000", obs[12:9]);
                end
            end
            if (k == 3) begin
                n_vec++;
                if ({obs[7:6], obs[3:0]} !== 6'b01_0000) begin
                    n_err++; $display("FAIL add_imm_w: got %b expected 010000", {obs[7:6], obs[3:0]});
                end
            end
        end
    endtask

    task automatic test_cmp_beq();
        logic [W-1:0] e;
        logic [19:0]  ins;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            ins = (k == 0) ? {4'he, 2'b00, 6'b010101, 4'h1, 4'h0} :
                  (k == 1) ? {4'h0, 2'b10, 14'h0} : NOP;
            cycle(ins, (k == 1) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL cmp_beq c%0d: got %h expected %h", k, obs, e); end
            if (k == 2) begin
                n_vec++;
                if (obs[4:0] !== 5'b1_0100) begin
                    n_err++; $display("FAIL cmp_flags: got %b expected 10100", obs[4:0]);
                end
            end
            if (k == 1 || k == 3) begin
                n_vec++;
                if (obs[4] !== 1'b1) begin
                    n_err++; $display("FAIL beq_pending c%0d: got %b expected 1", k, obs[4]);
                end
            end
            if (k == 4) begin
                n_vec++;
                if (obs[5:4] !== 2'b10) begin
                    n_err++; $display("FAIL beq_pcsrcw: got %b expected 10", obs[5:4]);
                end
            end
        end
    endtask

    task automatic test_failed_cond();
        logic [W-1:0] e;
        logic [19:0]  prog [7];
        prog = '{{4'he, 2'b00, 6'b010101, 4'h1, 4'h0},
                 {4'h1, 2'b00, 6'b101001, 4'h0, 4'h3},
                 {4'h1, 2'b01, 6'b011000, 4'h0, 4'h2},
                 {4'h1, 2'b10, 14'h0}, NOP, NOP, NOP};
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            cycle(prog[k], (k == 1) ? 4'b0100 : 4'b1011, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL failed_cond c%0d: got %h expected %h", k, obs, e); end
            if (k == 3) begin
                n_vec++;
                if (obs[4:0] !== 5'b1_0100) begin
                    n_err++; $display("FAIL ne_flags_kept: got %b expected 10100", obs[4:0]);
                end
            end
            if (k == 4) begin
                n_vec++;
                if ({obs[8], obs[6], obs[4]} !== 3'b000) begin
                    n_err++; $display("FAIL ne_no_write: got %b expected 000", {obs[8], obs[6], obs[4]});
                end
            end
            if (k == 6) begin
                n_vec++;
                if ({obs[5], obs[3:0]} !== 5'b0_0100) begin
                    n_err++; $display("FAIL bne_no_pc: got %b expected 00100", {obs[5], obs[3:0]});
                end
            end
        end
    endtask

    task automatic test_load_store();
        logic [W-1:0] e;
        logic [19:0]  prog [5];
        prog = '{{4'he, 2'b01, 6'b011001, 4'h0, 4'hf},
                 {4'he, 2'b01, 6'b011000, 4'h0, 4'h2}, NOP, NOP, NOP};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(prog[k], 4'h0, 1'b0, 1'b0);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL ldst c%0d: got %h expected %h", k, obs, e); end
            if (k == 0) begin
                n_vec++;
                if ({obs[16:13], obs[4]} !== 5'b0001_1) begin
                    n_err++; $display("FAIL ldr_decode: got %b expected 00011", {obs[16:13], obs[4]});
                end
            end
            if (k == 1) begin
                n_vec++;
                if (obs[16:13] !== 4'b1001) begin
                    n_err++; $display("FAIL str_decode: got %b expected 1001", obs[16:13]);
                end
            end
            if (k == 3) begin
                n_vec++;
                if (obs[8:5] !== 4'b1111) begin
                    n_err++; $display("FAIL ldr_w_str_m: got %b expected 1111", obs[8:5]);
                end
            end
            if (k == 4) begin
                n_vec++;
                if (obs[7:6] !== 2'b00) begin
                    n_err++; $display("FAIL str_w: got %b expected 00", obs[7:6]);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] e;
        logic [19:0]  prog [4];
        prog = '{{4'he, 2'b01, 6'b011000, 4'h0, 4'h2},
                 {4'he, 2'b01, 6'b011000, 4'h0, 4'h4}, NOP, NOP};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(prog[k], 4'h0, (k == 0), 1'b0);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL flush c%0d: got %h expected %h", k, obs, e); end
            if (k == 1) begin
                n_vec++;
                if (obs[12] !== 1'b0) begin
                    n_err++; $display("FAIL flush_bubble: got %b expected 0", obs[12]);
                end
            end
            if (k == 2) begin
                n_vec++;
                if ({obs[12], obs[8]} !== 2'b10) begin
                    n_err++; $display("FAIL flush_memw: got %b expected 10", {obs[12], obs[8]});
                end
            end
            if (k == 3) begin
                n_vec++;
                if (obs[8] !== 1'b1) begin
                    n_err++; $display("FAIL flush_next: got %b expected 1", obs[8]);
                end
            end
        end
    endtask

    task automatic test_midflight_reset();
        logic [W-1:0] e;
        logic [19:0]  prog [9];
        logic [3:0]   af;
        prog = '{{4'he, 2'b00, 6'b000101, 4'h0, 4'h5},
                 {4'he, 2'b10, 14'h0}, NOP, NOP,
                 {4'he, 2'b11, 14'h3fff},
                 {4'hf, 2'b00, 6'b001001, 4'h0, 4'hf}, NOP, NOP, NOP};
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            af = (k == 1) ? 4'b1011 : (k == 6) ? 4'hf : 4'h0;
            cycle(prog[k], af, 1'b0, (k == 2));
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL midreset c%0d: got %h expected %h", k, obs, e); end
            if (k == 2) begin
                n_vec++;
                if (obs[3:0] !== 4'b1011) begin
                    n_err++; $display("FAIL subs_flags: got %b expected 1011", obs[3:0]);
                end
            end
            if (k == 3) begin
                n_vec++;
                if (obs[12:0] !== 13'h0) begin
                    n_err++; $display("FAIL midreset_clear: got %h expected 0000", obs[12:0]);
                end
            end
            if (k == 5 || k == 6) begin
                n_vec++;
                if (obs[4] !== (k == 5)) begin
                    n_err++; $display("FAIL nv_pending c%0d: got %b expected %b", k, obs[4], (k == 5));
                end
            end
            if (k == 7 || k == 8) begin
                n_vec++;
                if ({obs[6:5], obs[3:0]} !== 6'h0) begin
                    n_err++; $display("FAIL nop_no_write c%0d: got %b expected 000000", k, {obs[6:5], obs[3:0]});
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] e;
        logic [19:0]  ins;
        logic         fl, rs;
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            ins = rand_instr();
            fl  = ($urandom_range(0, 7) == 0);
            rs  = ($urandom_range(0, 63) == 0);
            cycle(ins, 4'($urandom_range(0, 15)), fl, rs);
            e = exp_q.pop_front(); n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL random c%0d: got %h expected %h", k, obs, e); end
        end
    endtask

    initial begin
        reset    = 1'b1;
        InstrD   = NOP;
        ALUFlags = 4'h0;
        FlushE   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_add_imm();
        test_cmp_beq();
        test_failed_cond();
        test_load_store();
        test_flush();
        test_midflight_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
